// File: rtl/prml_pkg.sv
// Shared definitions for the PRML encoder and its paired decoder bench.
package prml_pkg;

    localparam logic PAIR_A = 1'b0;
    localparam logic PAIR_B = 1'b1;

    // Channel pair: a in bit 1, b in bit 0.
    typedef logic [1:0] pair_t;

    // a restores d against the previous b; b makes a^b equal the previous a.
    function automatic pair_t encode_pair(input pair_t prev, input logic d);
        logic a;
        a = prev[0] ^ d;
        return {a, a ^ prev[1]};
    endfunction

endpackage

// File: rtl/prml_encoder_if.sv
// Word-in / channel-bit-out bus between the upstream source and the PRML encoder.
interface prml_encoder_if #(parameter int W = 8);

    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         inject_err;
    logic         out_bit;
    logic         phase;
    logic         busy;

    modport master (
        output data_in, data_valid, inject_err,
        input  data_ready, out_bit, phase, busy
    );

    modport slave (
        input  data_in, data_valid, inject_err,
        output data_ready, out_bit, phase, busy
    );

endinterface

// File: rtl/prml_serializer.sv
// Word holding register: shifts a loaded word out MSB first, one bit per take strobe.
// Latency: a word accepted at edge k supplies its MSB from the next take onward.
// Backpressure: data_ready is low from load until the LSB has been consumed.
module prml_serializer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic         take,
    output logic         d,
    output logic         consumed,
    output logic         loaded
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  shift;
    logic [CW-1:0] bits_left;

    assign data_ready = ~loaded & ~reset;
    assign consumed   = take & loaded;
    assign d          = shift[W-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift     <= '0;
            bits_left <= '0;
            loaded    <= 1'b0;
        end else if (data_valid && data_ready) begin
            shift     <= data_in;
            bits_left <= CW'(W);
            loaded    <= 1'b1;
        end else if (consumed) begin
            shift     <= {shift[W-2:0], 1'b0};
            bits_left <= bits_left - CW'(1);
            if (bits_left == CW'(1))
                loaded <= 1'b0;
        end
    end

endmodule

// File: rtl/prml_encoder.sv
// PRML channel encoder: each data bit becomes an (a,b) pair sent serially, idle fills with 0.
// Latency: MSB's a appears at the first pair-start edge after acceptance; a word takes 2W clocks.
// Backpressure: one word in flight; data_ready low while a word still has unsent bits.
module prml_encoder import prml_pkg::*; #(
    parameter int W = 8
) (
    input  logic          clock,
    input  logic          reset,
    prml_encoder_if.slave bus
);

    logic  phase_q;
    logic  out_q;
    logic  b_hold;
    logic  prev_a;
    logic  prev_b;
    logic  ser_d;
    logic  consumed;
    logic  loaded;
    logic  d;
    logic  b_tx;
    pair_t pair;

    prml_serializer #(.W(W)) u_ser (
        .clock      (clock),
        .reset      (reset),
        .data_in    (bus.data_in),
        .data_valid (bus.data_valid),
        .data_ready (bus.data_ready),
        .take       (phase_q == PAIR_B),
        .d          (ser_d),
        .consumed   (consumed),
        .loaded     (loaded)
    );

    assign d    = consumed & ser_d;
    assign pair = encode_pair({prev_a, prev_b}, d);
    // prev_b follows the transmitted b so only the corrupted pair decodes wrong.
    assign b_tx = pair[0] ^ bus.inject_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= PAIR_B;
            out_q   <= 1'b0;
            b_hold  <= 1'b0;
            prev_a  <= 1'b0;
            prev_b  <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            if (phase_q == PAIR_B) begin
                out_q  <= pair[1];
                b_hold <= b_tx;
                prev_a <= pair[1];
                prev_b <= b_tx;
            end else begin
                out_q <= b_hold;
            end
        end
    end

    assign bus.out_bit = out_q;
    assign bus.phase   = phase_q;
    assign bus.busy    = loaded;

endmodule

// File: tb/tb_prml_encoder.sv
// Bench for prml_encoder: channel-stream model, inline pair decoder and directed/random stimulus.
module tb_prml_encoder;

    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    prml_encoder_if #(.W(W)) bus ();

    prml_encoder #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of pending data bits; every pair carries the next bit or a fill 0.
    bit         m_phase = 1'b1;
    bit         m_out   = 1'b0;
    bit         m_bhold = 1'b0;
    bit         m_pa    = 1'b0;
    bit         m_pb    = 1'b0;
    bit         m_bits[$];
    int         m_acc   = 0;
    logic [2:0] expq[$];   // {is_data, injected, d} per pair, oldest first

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase = 1'b1;
            m_out   = 1'b0;
            m_bhold = 1'b0;
            m_pa    = 1'b0;
            m_pb    = 1'b0;
            m_bits.delete();
            expq.delete();
        end else begin
            bit xfer, d, a, b, isdata;
            xfer = bus.data_valid && (m_bits.size() == 0);
            if (m_phase) begin
                isdata = (m_bits.size() != 0);
                d      = isdata ? m_bits.pop_front() : 1'b0;
                a      = d ^ m_pb;                    // decoder recovers d as prev b ^ a
                b      = (a ^ m_pa) ^ bus.inject_err; // legal pair has a^b == prev a
                m_out   = a;
                m_bhold = b;
                m_pa    = a;
                m_pb    = b;
                expq.push_back({isdata, bus.inject_err, d});
            end else begin
                m_out = m_bhold;
            end
            if (xfer) begin
                for (int i = W - 1; i >= 0; i--) m_bits.push_back(bus.data_in[i]);
                m_acc++;
            end
            m_phase = ~m_phase;
        end
    end

    always @(negedge clock) begin
        chk("out_bit",    32'(bus.out_bit),    32'(m_out));
        chk("phase",      32'(bus.phase),      32'(m_phase));
        chk("busy",       32'(bus.busy),       32'(m_bits.size() != 0));
        chk("data_ready", 32'(bus.data_ready), 32'((m_bits.size() == 0) && !reset));
    end

    // Inline channel decoder working only from out_bit/phase.
    bit         d_pa = 1'b0;
    bit         d_pb = 1'b0;
    bit         d_a  = 1'b0;
    logic [1:0] plog[$];
    bit         dlog[$];
    bit         elog[$];
    bit         flog[$];

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            d_pa = 1'b0;
            d_pb = 1'b0;
        end else if (bus.phase == 1'b0) begin
            d_a = bus.out_bit;
        end else begin
            bit b, err, dec;
            logic [2:0] e;
            b   = bus.out_bit;
            err = ((d_a ^ b) != d_pa);
            dec = err ? 1'b0 : (d_pb ^ d_a);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL decode_sync no pair expected at %0t", $time);
            end else begin
                e = expq.pop_front();
                chk("decoded_bit",   32'(dec), 32'(e[1] ? 1'b0 : e[0]));
                chk("decoder_error", 32'(err), 32'(e[1]));
                plog.push_back({d_a, b});
                dlog.push_back(dec);
                elog.push_back(err);
                flog.push_back(e[2]);
            end
            d_pa = d_a;
            d_pb = b;
        end
    end

    task automatic clear_logs();
        plog.delete();
        dlog.delete();
        elog.delete();
        flog.delete();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] w, input bit keep_valid);
        int start;
        start = m_acc;
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 100 && m_acc == start; i++) cyc(1);
        if (m_acc == start) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%0h never accepted", w);
        end
        if (!keep_valid) bus.data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && m_bits.size() != 0; i++) cyc(1);
        if (m_bits.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout bits_left=%0d", m_bits.size());
        end
        cyc(4);
    endtask

    task automatic collect(output logic [31:0] pairs, output logic [15:0] bits,
                           output int n, output int nerr, output int gap);
        int first, last;
        first = -1;
        last  = -1;
        pairs = '0;
        bits  = '0;
        n     = 0;
        nerr  = 0;
        gap   = 0;
        foreach (plog[i]) begin
            nerr += int'(elog[i]);
            if (flog[i]) begin
                if (first < 0) first = i;
                last  = i;
                n++;
                pairs = {pairs[29:0], plog[i]};
                bits  = {bits[14:0], dlog[i]};
            end
        end
        if (first >= 0)
            for (int i = first; i <= last; i++) if (!flog[i]) gap++;
    endtask

    initial begin
        logic [31:0] pairs;
        logic [15:0] bits;
        int          n, nerr, gap, ones;
        bit          done;

        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.inject_err = 1'b0;
        reset          = 1'b1;
        cyc(3);
        chk("rst_out_bit",    32'(bus.out_bit),    32'd0);
        chk("rst_phase",      32'(bus.phase),      32'd1);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_data_ready", 32'(bus.data_ready), 32'd0);

        reset = 1'b0;
        clear_logs();
        cyc(16);
        ones = 0;
        foreach (dlog[i]) ones += int'(dlog[i]);
        chk("idle_ones",   32'(ones),             32'd0);
        chk("idle_pairs",  32'(plog.size()),      32'd8);
        chk("idle_ready",  32'(bus.data_ready),   32'd1);

        // Single word A5
        clear_logs();
        send(8'hA5, 1'b0);
        wait_idle();
        collect(pairs, bits, n, nerr, gap);
        chk("a5_count",   32'(n),           32'd8);
        chk("a5_pairs",   pairs & 32'hFFFF, 32'b1110100111011101);
        chk("a5_decoded", 32'(bits[7:0]),   32'hA5);
        chk("a5_errors",  32'(nerr),        32'd0);

        // Back-to-back FF then 00 with valid held
        clear_logs();
        send(8'hFF, 1'b1);
        send(8'h00, 1'b0);
        wait_idle();
        collect(pairs, bits, n, nerr, gap);
        chk("b2b_count",   32'(n),        32'd16);
        chk("b2b_decoded", 32'(bits),     32'hFF00);
        chk("b2b_gap_le1", 32'(gap <= 1), 32'd1);
        chk("b2b_errors",  32'(nerr),     32'd0);

        // Error injection on the pair carrying bit 3 of 3C
        clear_logs();
        send(8'h3C, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 100 && m_bits.size() != 0; i++) begin
            if (!done && m_phase && m_bits.size() == 4) begin
                bus.inject_err = 1'b1;
                done = 1'b1;
            end else begin
                bus.inject_err = 1'b0;
            end
            cyc(1);
        end
        bus.inject_err = 1'b0;
        wait_idle();
        collect(pairs, bits, n, nerr, gap);
        chk("inj_count",   32'(n),          32'd8);
        chk("inj_decoded", 32'(bits[7:0]),  32'h34);
        chk("inj_errors",  32'(nerr),       32'd1);

        // Valid held and data_in churning while a word is in flight
        send(8'h5A, 1'b0);
        bus.data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = W'($urandom);
            cyc(1);
            chk("held_ready_low", 32'(bus.data_ready), 32'd0);
        end
        bus.data_valid = 1'b0;
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.data_valid = 1'($urandom_range(0, 1));
            bus.data_in    = W'($urandom);
            bus.inject_err = ($urandom_range(0, 19) == 0);
            cyc(1);
        end
        bus.data_valid = 1'b0;
        bus.inject_err = 1'b0;
        wait_idle();

        // Asynchronous reset after 5 bits of 81
        send(8'h81, 1'b0);
        for (int i = 0; i < 100 && m_bits.size() > 3; i++) cyc(1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_bit",    32'(bus.out_bit),    32'd0);
        chk("arst_phase",      32'(bus.phase),      32'd1);
        chk("arst_busy",       32'(bus.busy),       32'd0);
        chk("arst_data_ready", 32'(bus.data_ready), 32'd0);
        cyc(2);
        reset = 1'b0;
        clear_logs();
        cyc(20);
        collect(pairs, bits, n, nerr, gap);
        ones = 0;
        foreach (dlog[i]) ones += int'(dlog[i]);
        chk("arst_data_pairs", 32'(n),    32'd0);
        chk("arst_ones",       32'(ones), 32'd0);
        chk("arst_errors",     32'(nerr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/prml_encoder.md
Name: prml_encoder

Overview:
- Transmit-side stage that sits directly upstream of the PRML Viterbi decoder.
- Accepts parallel data words over a valid/ready handshake and serialises them MSB first.
- Encodes each data bit as a 2-bit channel pair that the decoder recovers error-free; pairs leave on `out_bit`, one channel bit per clock, and `out_bit` drives the decoder's `in`.
- Provides idle fill and a single-pair error-injection hook, so the decoder's error flag can be exercised end to end.

Parameters:
- W, 8, data word width in bits (≥2).

Ports:
- clock  input  1  system clock; one channel bit per rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  W  word to transmit; sent MSB first.
- data_valid  input  1  data_in holds a word.
- data_ready  output  1  encoder can accept a word (combinational: ~loaded & ~reset).
- inject_err  input  1  when high at a pair-start edge, the second bit of that pair is inverted.
- out_bit  output  1  serial channel bit to the decoder.
- phase  output  1  0 = first bit (a) of the pair on out_bit; 1 = second bit (b).
- busy  output  1  a word is loaded and still has unsent bits.

Behaviour:
- State: phase, out_bit, b_hold, prev_a, prev_b, shift[W-1:0], bits_left (clog2(W+1) bits), loaded, inj_hold.
- Reset values (asynchronous): phase=1, out_bit=0, b_hold=0, prev_a=0, prev_b=0, loaded=0, bits_left=0, shift=0, busy=0. data_ready=0 while reset is high.
- Phase toggles on every clock edge. The first edge after reset deasserts is a pair-start edge (phase 1→0).
- Pair-start edge (phase==1 before the edge):
  - Select data bit d: if loaded, d=shift[W-1], shift left by 1, decrement bits_left, and clear loaded when bits_left goes 1→0. If not loaded, d=0 (idle fill).
  - Compute a = prev_b ^ d and b = a ^ prev_a ^ inject_err.
  - Drive out_bit<=a, b_hold<=b, prev_a<=a, prev_b<=b.
  - prev_b always tracks the transmitted (possibly corrupted) b, so the following pair decodes correctly.
- Mid-pair edge (phase==0 before the edge): out_bit<=b_hold.
- Decode relation:
  - Decoded bit = previous pair's b XOR this pair's a, which equals d.
  - A pair is legal iff a^b equals the previous pair's a; an injected pair violates this.
  - Result: the decoder asserts error for exactly that pair, outputs 0 for it, and decodes every later pair correctly.
- Latency from data_in, out_bit view:
  - Accept at edge k.
  - MSB's a appears at the next pair-start edge (k+1 or k+2).
  - Word occupies 2W cycles.
- Handshake:
  - Transfer occurs when data_valid && data_ready at an edge; then loaded<=1, shift<=data_in, bits_left<=W.
  - data_ready stays low until the LSB has been consumed.
  - With data_valid held high, words go back to back with at most one fill pair between them: a load at a pair-start edge uses fill for that pair, because data_ready was high, so nothing was loaded.
  - data_valid with ready low: the word is held upstream; no loss, no duplication.
- Idle: continuous fill pairs that decode to 0 with no error.
- Reset mid-word: the word is discarded, the encoder state returns to 00, and the first pair after reset is a fill pair. The decoder must be reset together with this block to stay aligned.
- busy = loaded.

Decomposition:
- Shared package prml_pkg holds:
  - PAIR_A / PAIR_B phase constants.
  - Channel-pair typedef (logic [1:0], a in bit 1).
  - pure function encode_pair(prev, d) returning the pair.
- The decoder-side bench reuses the same package.
- Natural single sub-module: prml_serializer (shift register, bits_left counter, handshake), producing d and a bit-consumed strobe.
- The pair encoder and phase logic stay in the top module.

Test Plan:
- Reset, then idle for 16 cycles -> out_bit=0 every cycle, phase alternates starting at 0, data_ready=1, busy=0.
- Single word 8'hA5 from reset state -> pairs (a,b) = 11 10 10 01 11 01 11 01 over 16 cycles; busy falls after the last pair starts; the paired decoder outputs 1,0,1,0,0,1,0,1 with error=0.
- Back-to-back words 8'hFF then 8'h00 with data_valid held -> each word accepted exactly once; at most one fill pair between the words; decoded stream is eight 1s, optionally a 0, then eight 0s; no error.
- inject_err=1 for one pair-start edge during bit 3 of 8'h3C -> that pair's b is inverted; decoder error pulses for exactly one decode; decoded bit 3 reads 0; every other bit matches 8'h3C.
- Valid withheld mid-stream -> data_ready stays 0 while busy; data_in changes while ready=0 are ignored.
- Reset asserted asynchronously after 5 bits of 8'h81 -> all outputs take reset values immediately; after release the output is fill pairs only and the remaining bits are never sent.
